// File: rtl/ex_stage_core.sv
// ex_stage_core: MIPS execute stage - decode, operand forwarding, ALU and the E->M pipeline register.
module ex_stage_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] Instr,
    input  logic [31:0] GRFRData1,
    input  logic [31:0] GRFRData2,
    input  logic [31:0] Imm,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] W_GRFWData,
    input  logic [1:0]  Trans_ALUIn_Sel1,
    input  logic [1:0]  Trans_ALUIn_Sel2,
    output logic [31:0] RData1,
    output logic [31:0] RData2,
    output logic [31:0] ALUResult,
    output logic [4:0]  ReadA1,
    output logic [4:0]  ReadA2,
    output logic [4:0]  WriteA,
    output logic        RegWrite,
    output logic [31:0] M_ALUResult_q,
    output logic [31:0] M_RData2_q,
    output logic [4:0]  M_WriteA_q,
    output logic        M_RegWrite_q
);
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, aluop;
    logic        alusrc, rw;
    logic [31:0] b;
    assign op    = Instr[31:26];
    assign rs    = Instr[25:21];
    assign rt    = Instr[20:16];
    assign rd    = Instr[15:11];
    assign shamt = Instr[10:6];
    assign funct = Instr[5:0];
    assign RData1 = Trans_ALUIn_Sel1 == 2'd0 ? GRFRData1 : Trans_ALUIn_Sel1 == 2'd1 ? M_ALUResult :
                    Trans_ALUIn_Sel1 == 2'd2 ? W_GRFWData : 32'h0;
    assign RData2 = Trans_ALUIn_Sel2 == 2'd0 ? GRFRData2 : Trans_ALUIn_Sel2 == 2'd1 ? M_ALUResult :
                    Trans_ALUIn_Sel2 == 2'd2 ? W_GRFWData : 32'h0;
    assign b = alusrc ? Imm : RData2;
    assign RegWrite = rw && WriteA != 5'd0;
    always_comb begin
        aluop  = 5'd0;
        alusrc = 1'b0;
        ReadA1 = 5'd0;
        ReadA2 = 5'd0;
        WriteA = 5'd0;
        rw     = 1'b0;
        case (op)
            6'h00: begin
                ReadA1 = rs;
                ReadA2 = rt;
                WriteA = rd;
                rw     = 1'b1;
                case (funct)
                    6'h20, 6'h21: aluop = 5'd0;
                    6'h22, 6'h23: aluop = 5'd1;
                    6'h24: aluop = 5'd2;
                    6'h25: aluop = 5'd3;
                    6'h26: aluop = 5'd4;
                    6'h27: aluop = 5'd5;
                    6'h2A: aluop = 5'd6;
                    6'h2B: aluop = 5'd7;
                    6'h00, 6'h02, 6'h03: begin
                        aluop  = funct == 6'h00 ? 5'd8 : funct == 6'h02 ? 5'd9 : 5'd10;
                        ReadA1 = 5'd0;
                    end
                    6'h04: aluop = 5'd12;
                    6'h06: aluop = 5'd13;
                    6'h07: aluop = 5'd14;
                    6'h08: begin
                        ReadA2 = 5'd0;
                        WriteA = 5'd0;
                        rw     = 1'b0;
                    end
                    default: begin
                        ReadA1 = 5'd0;
                        ReadA2 = 5'd0;
                        WriteA = 5'd0;
                        rw     = 1'b0;
                    end
                endcase
            end
            6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
                aluop  = op == 6'h0A ? 5'd6 : op == 6'h0C ? 5'd2 : op == 6'h0D ? 5'd3 :
                         op == 6'h0E ? 5'd4 : op == 6'h0F ? 5'd11 : 5'd0;
                ReadA1 = op == 6'h0F ? 5'd0 : rs;
                WriteA = rt;
                rw     = 1'b1;
                alusrc = 1'b1;
            end
            6'h2B: begin
                ReadA1 = rs;
                ReadA2 = rt;
                alusrc = 1'b1;
            end
            6'h04, 6'h05: begin
                aluop  = 5'd1;
                ReadA1 = rs;
                ReadA2 = rt;
            end
            // jal selects an unused ALU code so the result is 0; the link value is added later
            6'h03: begin
                aluop  = 5'd31;
                WriteA = 5'd31;
                rw     = 1'b1;
            end
            default: ;
        endcase
    end
    always_comb begin
        case (aluop)
            5'd0:    ALUResult = RData1 + b;
            5'd1:    ALUResult = RData1 - b;
            5'd2:    ALUResult = RData1 & b;
            5'd3:    ALUResult = RData1 | b;
            5'd4:    ALUResult = RData1 ^ b;
            5'd5:    ALUResult = ~(RData1 | b);
            5'd6:    ALUResult = 32'($signed(RData1) < $signed(b));
            5'd7:    ALUResult = 32'(RData1 < b);
            5'd8:    ALUResult = b << shamt;
            5'd9:    ALUResult = b >> shamt;
            5'd10:   ALUResult = $signed(b) >>> shamt;
            5'd11:   ALUResult = b << 16;
            5'd12:   ALUResult = b << RData1[4:0];
            5'd13:   ALUResult = b >> RData1[4:0];
            5'd14:   ALUResult = $signed(b) >>> RData1[4:0];
            default: ALUResult = 32'h0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            M_ALUResult_q <= 32'h0;
            M_RData2_q    <= 32'h0;
            M_WriteA_q    <= 5'd0;
            M_RegWrite_q  <= 1'b0;
        end else if (en) begin
            M_ALUResult_q <= ALUResult;
            M_RData2_q    <= RData2;
            M_WriteA_q    <= WriteA;
            M_RegWrite_q  <= RegWrite;
        end
    end
endmodule

// File: tb/tb_ex_stage_core.sv
// tb_ex_stage_core: vector table for the combinational outputs, scoreboard queue for the E->M register.
module tb_ex_stage_core;
    logic        clk, reset, en, flush;
    logic [31:0] Instr, GRFRData1, GRFRData2, Imm, M_ALUResult, W_GRFWData;
    logic [1:0]  Trans_ALUIn_Sel1, Trans_ALUIn_Sel2;
    logic [31:0] RData1, RData2, ALUResult, M_ALUResult_q, M_RData2_q;
    logic [4:0]  ReadA1, ReadA2, WriteA, M_WriteA_q;
    logic        RegWrite, M_RegWrite_q;

    ex_stage_core dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .Instr(Instr),
        .GRFRData1(GRFRData1), .GRFRData2(GRFRData2), .Imm(Imm),
        .M_ALUResult(M_ALUResult), .W_GRFWData(W_GRFWData),
        .Trans_ALUIn_Sel1(Trans_ALUIn_Sel1), .Trans_ALUIn_Sel2(Trans_ALUIn_Sel2),
        .RData1(RData1), .RData2(RData2), .ALUResult(ALUResult),
        .ReadA1(ReadA1), .ReadA2(ReadA2), .WriteA(WriteA), .RegWrite(RegWrite),
        .M_ALUResult_q(M_ALUResult_q), .M_RData2_q(M_RData2_q),
        .M_WriteA_q(M_WriteA_q), .M_RegWrite_q(M_RegWrite_q)
    );

    typedef struct {
        logic [31:0] instr, d1, d2, imm, malu, wdata;
        logic [1:0]  s1, s2;
        logic [31:0] alu, r1, r2;
        logic [4:0]  ra1, ra2, wa;
        logic        rw;
    } vec_t;
    typedef struct {
        logic [31:0] alu, r2;
        logic [4:0]  wa;
        logic        rw;
    } q_t;

    vec_t vecs[$];
    q_t   sb[$];
    int   checks = 0, errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] instr, d1, d2, imm, malu, wdata,
                                input logic [1:0] s1, s2, input logic [31:0] alu, r1, r2,
                                input logic [4:0] ra1, ra2, wa, input logic rw);
        vec_t v;
        v.instr = instr; v.d1 = d1; v.d2 = d2; v.imm = imm; v.malu = malu; v.wdata = wdata;
        v.s1 = s1; v.s2 = s2; v.alu = alu; v.r1 = r1; v.r2 = r2;
        v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.rw = rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Instr = v.instr; GRFRData1 = v.d1; GRFRData2 = v.d2; Imm = v.imm;
        M_ALUResult = v.malu; W_GRFWData = v.wdata;
        Trans_ALUIn_Sel1 = v.s1; Trans_ALUIn_Sel2 = v.s2;
    endtask

    task automatic check_comb(input vec_t v, input int i);
        chk($sformatf("v%0d RData1", i), RData1, v.r1);
        chk($sformatf("v%0d RData2", i), RData2, v.r2);
        chk($sformatf("v%0d ALUResult", i), ALUResult, v.alu);
        chk($sformatf("v%0d ReadA1", i), 32'(ReadA1), 32'(v.ra1));
        chk($sformatf("v%0d ReadA2", i), 32'(ReadA2), 32'(v.ra2));
        chk($sformatf("v%0d WriteA", i), 32'(WriteA), 32'(v.wa));
        chk($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(v.rw));
    endtask

    task automatic push(input logic [31:0] alu, r2, input logic [4:0] wa, input logic rw);
        q_t e;
        e.alu = alu; e.r2 = r2; e.wa = wa; e.rw = rw;
        sb.push_back(e);
    endtask

    // one clock edge later, the oldest expectation must be visible on the *_q outputs
    task automatic edge_check(input string name);
        q_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, M_ALUResult_q);
        end else begin
            e = sb.pop_front();
            chk({name, " M_ALUResult_q"}, M_ALUResult_q, e.alu);
            chk({name, " M_RData2_q"}, M_RData2_q, e.r2);
            chk({name, " M_WriteA_q"}, 32'(M_WriteA_q), 32'(e.wa));
            chk({name, " M_RegWrite_q"}, 32'(M_RegWrite_q), 32'(e.rw));
        end
    endtask

    initial begin
        vecs.push_back(mk(32'h00221821, 32'h5, 32'h7, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'hC, 32'h5, 32'h7, 5'd1, 5'd2, 5'd3, 1'b1));
        vecs.push_back(mk(32'h3404FFFF, 32'h0, 32'h11111111, 32'h0000FFFF, 32'hF0F00000, 32'h0, 2'd1, 2'd0, 32'hF0F0FFFF, 32'hF0F00000, 32'h11111111, 5'd0, 5'd0, 5'd4, 1'b1));
        vecs.push_back(mk(32'h00062903, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h80000000, 2'd0, 2'd2, 32'hF8000000, 32'h12345678, 32'h80000000, 5'd0, 5'd6, 5'd5, 1'b1));
        vecs.push_back(mk(32'h00062903, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h80000000, 2'd0, 2'd3, 32'h0, 32'h12345678, 32'h0, 5'd0, 5'd6, 5'd5, 1'b1));
        vecs.push_back(mk(32'hAC220008, 32'h100, 32'hDEADBEEF, 32'h8, 32'h0, 32'h0, 2'd0, 2'd0, 32'h108, 32'h100, 32'hDEADBEEF, 5'd1, 5'd2, 5'd0, 1'b0));
        vecs.push_back(mk(32'h0C000010, 32'h5, 32'h7, 32'h10, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h5, 32'h7, 5'd0, 5'd0, 5'd31, 1'b1));
        vecs.push_back(mk(32'h00000000, 32'h3, 32'h7, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h7, 32'h3, 32'h7, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'h3C071234, 32'h9, 32'h9, 32'h1234, 32'h0, 32'h0, 2'd0, 2'd0, 32'h12340000, 32'h9, 32'h9, 5'd0, 5'd0, 5'd7, 1'b1));
        vecs.push_back(mk(32'h0022402A, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h1, 32'hFFFFFFFF, 32'h1, 5'd1, 5'd2, 5'd8, 1'b1));
        vecs.push_back(mk(32'h0022402B, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd1, 5'd2, 5'd8, 1'b1));
        vecs.push_back(mk(32'h10220003, 32'hA, 32'h3, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h7, 32'hA, 32'h3, 5'd1, 5'd2, 5'd0, 1'b0));
        vecs.push_back(mk(32'h00221823, 32'h3, 32'h5, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'hFFFFFFFE, 32'h3, 32'h5, 5'd1, 5'd2, 5'd3, 1'b1));
        vecs.push_back(mk(32'h00221804, 32'h24, 32'h1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h10, 32'h24, 32'h1, 5'd1, 5'd2, 5'd3, 1'b1));
        vecs.push_back(mk(32'h03E00008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'hFC221821, 32'h4, 32'h6, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'hA, 32'h4, 32'h6, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'h382900FF, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0F0F0F0F, 2'd2, 2'd0, 32'h0F0F0FF0, 32'h0F0F0F0F, 32'h0, 5'd1, 5'd0, 5'd9, 1'b1));
        vecs.push_back(mk(32'h00221827, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h00000F0F, 32'hF0F0F0F0, 32'h0F0F0000, 5'd1, 5'd2, 5'd3, 1'b1));
        vecs.push_back(mk(32'h00221807, 32'h23, 32'h80000010, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'hF0000002, 32'h23, 32'h80000010, 5'd1, 5'd2, 5'd3, 1'b1));
        vecs.push_back(mk(32'h8C25FFFC, 32'h100, 32'h55, 32'hFFFFFFFC, 32'h0, 32'h0, 2'd0, 2'd0, 32'hFC, 32'h100, 32'h55, 5'd1, 5'd0, 5'd5, 1'b1));

        reset = 1'b0; en = 1'b1; flush = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        push(32'h0, 32'h0, 5'd0, 1'b0);
        edge_check("reset");
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_comb(vecs[i], i);
            push(vecs[i].alu, vecs[i].r2, vecs[i].wa, vecs[i].rw);
            edge_check($sformatf("v%0d", i));
        end

        // en=0 holds the last captured (lw) payload despite a new instruction
        en = 1'b0;
        drive(vecs[0]);
        push(32'hFC, 32'h55, 5'd5, 1'b1);
        edge_check("hold");

        en = 1'b1; flush = 1'b1;
        push(32'h0, 32'h0, 5'd0, 1'b0);
        edge_check("flush");

        flush = 1'b0;
        push(32'hC, 32'h7, 5'd3, 1'b1);
        edge_check("reload");

        reset = 1'b0;
        push(32'h0, 32'h0, 5'd0, 1'b0);
        edge_check("reset2");
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
